// File: rtl/ro_seq_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
// RO_SEQ_CHECKSUM_EN adds a trailing XOR checksum byte to each frame.
package ro_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GATE,
    ST_HOLD,
    ST_ACCUM,
    ST_SEND
  } seq_state_t;

  localparam logic [7:0] CMD_MEAS = 8'h4D;
  localparam logic [7:0] CMD_CONT = 8'h43;
  localparam logic [7:0] CMD_STOP = 8'h53;

  localparam logic [7:0] HDR_OK  = 8'hA5;
  localparam logic [7:0] HDR_SAT = 8'hA7;

`ifdef RO_SEQ_CHECKSUM_EN
  localparam int unsigned FRAME_LEN = 6;
`else
  localparam int unsigned FRAME_LEN = 5;
`endif

  localparam int unsigned BYTE_IDX_W = 3;

endpackage

// File: rtl/ro_frame_tx.sv
// Result frame byte selection and UART transmit handshake.
// RO_SEQ_CHECKSUM_EN appends the XOR of the first five bytes.
module ro_frame_tx
  import ro_seq_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active,
  input  logic [BYTE_IDX_W-1:0] byte_idx,
  input  logic                  sat,
  input  logic [15:0]           inv_res,
  input  logic [15:0]           nand_res,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  frame_done_c
);

  logic       wait_q;
  logic       fire_c;
  logic [7:0] hdr_c;
  logic [7:0] byte_sel_c;

  assign hdr_c = sat ? HDR_SAT : HDR_OK;

`ifdef RO_SEQ_CHECKSUM_EN
  logic [7:0] csum_c;
  assign csum_c = hdr_c ^ inv_res[15:8] ^ inv_res[7:0] ^ nand_res[15:8] ^ nand_res[7:0];
`endif

  always_comb begin
    byte_sel_c = 8'h00;
    case (byte_idx)
      3'd0:    byte_sel_c = hdr_c;
      3'd1:    byte_sel_c = inv_res[15:8];
      3'd2:    byte_sel_c = inv_res[7:0];
      3'd3:    byte_sel_c = nand_res[15:8];
      3'd4:    byte_sel_c = nand_res[7:0];
`ifdef RO_SEQ_CHECKSUM_EN
      3'd5:    byte_sel_c = csum_c;
`endif
      default: byte_sel_c = 8'h00;
    endcase
  end

  // One idle cycle after each start lets the transmitter raise tx_busy before we look again
  assign fire_c       = active && !tx_start && !wait_q && !tx_busy;
  assign frame_done_c = tx_start && (byte_idx == BYTE_IDX_W'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_start <= 1'b0;
      wait_q   <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      tx_start <= fire_c;
      wait_q   <= tx_start;
      tx_data  <= active ? byte_sel_c : 8'h00;
    end
  end

endmodule

// File: rtl/ro_measure_sequencer.sv
// Sequences inverter/NAND ring-oscillator counting windows, averages them and sends a result frame.
// RO_SEQ_CHECKSUM_EN (see ro_frame_tx) selects the 6-byte checksummed frame.
module ro_measure_sequencer
  import ro_seq_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 10000,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned SAMPLES_LOG2  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic [15:0] count,
  input  logic        tx_busy,
  output logic        en_inv_osc,
  output logic        en_nand_osc,
  output logic        osc_sel,
  output logic        cnt_en,
  output logic        cnt_clear,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy
);

  localparam int unsigned TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam int unsigned ACC_W   = 16 + SAMPLES_LOG2;
  localparam int unsigned SMP_W   = (SAMPLES_LOG2 > 0) ? SAMPLES_LOG2 : 1;

  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [SMP_W-1:0] SMP_LAST    = SMP_W'((1 << SAMPLES_LOG2) - 1);

  seq_state_t            state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [SMP_W-1:0]      smp_q, smp_d;
  logic                  osc_q, osc_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [15:0]           inv_res_q, inv_res_d;
  logic [15:0]           nand_res_q, nand_res_d;
  logic                  cont_q, cont_d;
  logic                  sat_q, sat_d;
  logic [BYTE_IDX_W-1:0] byte_idx_q, byte_idx_d;

  logic             cmd_meas_c, cmd_cont_c, cmd_stop_c;
  logic [ACC_W-1:0] acc_sum_c;
  logic             frame_done_c;
  logic             run_d;

  assign cmd_meas_c = rx_ready && (rx_data == CMD_MEAS);
  assign cmd_cont_c = rx_ready && (rx_data == CMD_CONT);
  assign cmd_stop_c = rx_ready && (rx_data == CMD_STOP);
  assign acc_sum_c  = acc_q + ACC_W'(count);

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    smp_d      = smp_q;
    osc_d      = osc_q;
    acc_d      = acc_q;
    inv_res_d  = inv_res_q;
    nand_res_d = nand_res_q;
    cont_d     = cont_q;
    sat_d      = sat_q;
    byte_idx_d = byte_idx_q;

    if (cmd_stop_c) cont_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_meas_c || cmd_cont_c) begin
          state_d = ST_SETTLE;
          tmr_d   = '0;
          smp_d   = '0;
          osc_d   = 1'b0;
          acc_d   = '0;
          sat_d   = 1'b0;
          cont_d  = cmd_cont_c;
        end
      end
      ST_SETTLE: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == SETTLE_LAST) begin
          state_d = ST_GATE;
          tmr_d   = '0;
        end
      end
      ST_GATE: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == WINDOW_LAST) begin
          state_d = ST_HOLD;
          tmr_d   = '0;
        end
      end
      ST_HOLD: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == SETTLE_LAST) begin
          state_d = ST_ACCUM;
          tmr_d   = '0;
        end
      end
      ST_ACCUM: begin
        if (count == 16'hFFFF) sat_d = 1'b1;
        state_d = ST_SETTLE;
        tmr_d   = '0;
        acc_d   = acc_sum_c;
        smp_d   = smp_q + SMP_W'(1);
        if (smp_q == SMP_LAST) begin
          acc_d = '0;
          smp_d = '0;
          if (!osc_q) begin
            inv_res_d = 16'(acc_sum_c >> SAMPLES_LOG2);
            osc_d     = 1'b1;
          end else begin
            nand_res_d = 16'(acc_sum_c >> SAMPLES_LOG2);
            state_d    = ST_SEND;
            byte_idx_d = '0;
          end
        end
      end
      ST_SEND: begin
        if (tx_start) byte_idx_d = byte_idx_q + BYTE_IDX_W'(1);
        if (frame_done_c) begin
          // A command arriving with the last handoff is judged by the state we move into
          if (cont_q || cmd_meas_c || cmd_cont_c) begin
            state_d = ST_SETTLE;
            tmr_d   = '0;
            smp_d   = '0;
            osc_d   = 1'b0;
            acc_d   = '0;
            sat_d   = 1'b0;
            if (!cont_q) cont_d = cmd_cont_c;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign run_d = (state_d == ST_SETTLE) || (state_d == ST_GATE) ||
                 (state_d == ST_HOLD)   || (state_d == ST_ACCUM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      smp_q       <= '0;
      osc_q       <= 1'b0;
      acc_q       <= '0;
      inv_res_q   <= '0;
      nand_res_q  <= '0;
      cont_q      <= 1'b0;
      sat_q       <= 1'b0;
      byte_idx_q  <= '0;
      en_inv_osc  <= 1'b0;
      en_nand_osc <= 1'b0;
      osc_sel     <= 1'b0;
      cnt_en      <= 1'b0;
      cnt_clear   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      smp_q       <= smp_d;
      osc_q       <= osc_d;
      acc_q       <= acc_d;
      inv_res_q   <= inv_res_d;
      nand_res_q  <= nand_res_d;
      cont_q      <= cont_d;
      sat_q       <= sat_d;
      byte_idx_q  <= byte_idx_d;
      en_inv_osc  <= run_d && !osc_d;
      en_nand_osc <= run_d && osc_d;
      osc_sel     <= run_d && osc_d;
      cnt_en      <= (state_d == ST_GATE);
      cnt_clear   <= (state_d == ST_SETTLE) && (state_q != ST_SETTLE);
      busy        <= (state_d != ST_IDLE);
    end
  end

  ro_frame_tx u_frame_tx (
    .clk          (clk),
    .reset        (reset),
    .active       (state_q == ST_SEND),
    .byte_idx     (byte_idx_q),
    .sat          (sat_q),
    .inv_res      (inv_res_q),
    .nand_res     (nand_res_q),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .frame_done_c (frame_done_c)
  );

endmodule

// File: tb/tb_ro_measure_sequencer.sv
// Directed bench for ro_measure_sequencer with a simple UART transmitter model.
module tb_ro_measure_sequencer;
  import ro_seq_pkg::*;

  localparam int unsigned WIN    = 20;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned SLOG2  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic [15:0] count = 16'h0000;
  logic        tx_busy;
  logic        en_inv_osc, en_nand_osc, osc_sel, cnt_en, cnt_clear, tx_start, busy;
  logic [7:0]  tx_data;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  int          mode = 0;
  logic [15:0] const_val = 16'h0000;
  int          busy_len = 3;
  int          busy_cnt = 0;
  int          win_idx = 0;
  logic        en_q = 1'b0;
  int          viol = 0;
  logic [7:0]  cap[$];
  logic        onehot_err = 1'b0;

  ro_measure_sequencer #(
    .WINDOW_CYCLES (WIN),
    .SETTLE_CYCLES (SETTLE),
    .SAMPLES_LOG2  (SLOG2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .count       (count),
    .tx_busy     (tx_busy),
    .en_inv_osc  (en_inv_osc),
    .en_nand_osc (en_nand_osc),
    .osc_sel     (osc_sel),
    .cnt_en      (cnt_en),
    .cnt_clear   (cnt_clear),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Transmitter: busy from the cycle after a start for busy_len cycles
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  function automatic logic [15:0] sample_val(input int w);
    int k;
    k = w % 16;
    case (mode)
      1:       return (k < 8) ? 16'(100 + k) : 16'd200;
      2:       return (k == 3) ? 16'hFFFF : 16'h1000;
      default: return const_val;
    endcase
  endfunction

  // Output monitor and counter model, sampled away from the active edge
  always @(negedge clk) begin
    if (tx_start) begin
      cap.push_back(tx_data);
      if (tx_busy) viol = viol + 1;
    end
    if (en_inv_osc && en_nand_osc) onehot_err = 1'b1;
    if (en_q && !cnt_en) begin
      count = sample_val(win_idx);
      win_idx = win_idx + 1;
    end
    if (!busy) win_idx = 0;
    en_q = cnt_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget, input logic need_idle);
    int   i;
    logic ok;
    ok = 1'b0;
    for (i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (cap.size() >= n && (!need_idle || !busy)) ok = 1'b1;
    end
    check({tag, " done"}, 32'(ok), 32'd1);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] hdr,
                             input logic [15:0] inv, input logic [15:0] nand_v);
    logic [7:0] exp[6];
    logic [31:0] got;
    exp[0] = hdr;
    exp[1] = inv[15:8];
    exp[2] = inv[7:0];
    exp[3] = nand_v[15:8];
    exp[4] = nand_v[7:0];
    exp[5] = exp[0] ^ exp[1] ^ exp[2] ^ exp[3] ^ exp[4];
    for (int i = 0; i < int'(FRAME_LEN); i++) begin
      got = (base + i < cap.size()) ? 32'(cap[base + i]) : 32'hDEAD;
      check($sformatf("%s byte%0d", tag, i), got, 32'(exp[i]));
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " en_inv"},  32'(en_inv_osc),  32'd0);
    check({tag, " en_nand"}, 32'(en_nand_osc), 32'd0);
    check({tag, " osc_sel"}, 32'(osc_sel),     32'd0);
    check({tag, " cnt_en"},  32'(cnt_en),      32'd0);
    check({tag, " cnt_clr"}, 32'(cnt_clear),   32'd0);
    check({tag, " tx_start"},32'(tx_start),    32'd0);
    check({tag, " tx_data"}, 32'(tx_data),     32'd0);
    check({tag, " busy"},    32'(busy),        32'd0);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Unknown byte and stop in IDLE are ignored
    send_cmd(8'h58);
    check("ignore X busy", 32'(busy), 32'd0);
    send_cmd(CMD_STOP);
    check("ignore S busy", 32'(busy), 32'd0);

    // Single run with constant count
    mode = 0; const_val = 16'h1234; base = cap.size();
    send_cmd(CMD_MEAS);
    check("M busy next", 32'(busy), 32'd1);
    check("M inv en", 32'(en_inv_osc), 32'd1);
    wait_bytes("single", base + int'(FRAME_LEN), 20000, 1'b1);
    check_frame("single", base, 8'hA5, 16'h1234, 16'h1234);
    check("single busy", 32'(busy), 32'd0);

    // Averaging: 100..107 on inverter, 200 on NAND; a mid-run 'M' is ignored
    mode = 1; base = cap.size();
    send_cmd(CMD_MEAS);
    repeat (50) @(negedge clk);
    send_cmd(CMD_MEAS);
    wait_bytes("avg", base + int'(FRAME_LEN), 20000, 1'b1);
    check_frame("avg", base, 8'hA5, 16'h0067, 16'h00C8);
    repeat (600) @(negedge clk);
    check("avg no extra", 32'(cap.size()), 32'(base + int'(FRAME_LEN)));

    // Saturation: one 0xFFFF sample
    mode = 2; base = cap.size();
    send_cmd(CMD_MEAS);
    wait_bytes("sat", base + int'(FRAME_LEN), 20000, 1'b1);
    check_frame("sat", base, 8'hA7, 16'h2DFF, 16'h1000);

    // Continuous: frame 1 repeats, 'S' mid-window of frame 2 ends after frame 2
    mode = 0; const_val = 16'h0042; base = cap.size();
    send_cmd(CMD_CONT);
    wait_bytes("cont1", base + int'(FRAME_LEN), 20000, 1'b0);
    repeat (4) @(negedge clk);
    check("cont still busy", 32'(busy), 32'd1);
    check_frame("cont1", base, 8'hA5, 16'h0042, 16'h0042);
    while (!cnt_en) @(negedge clk);
    repeat (5) @(negedge clk);
    send_cmd(CMD_STOP);
    wait_bytes("cont2", base + 2 * int'(FRAME_LEN), 20000, 1'b1);
    check_frame("cont2", base + int'(FRAME_LEN), 8'hA5, 16'h0042, 16'h0042);
    repeat (800) @(negedge clk);
    check("cont stopped", 32'(cap.size()), 32'(base + 2 * int'(FRAME_LEN)));
    check("cont idle", 32'(busy), 32'd0);

    // Slow transmitter handshake
    busy_len = 500; const_val = 16'hBEEF; base = cap.size();
    send_cmd(CMD_MEAS);
    wait_bytes("slow", base + int'(FRAME_LEN), 20000, 1'b1);
    check_frame("slow", base, 8'hA5, 16'hBEEF, 16'hBEEF);
    busy_len = 3;
    repeat (10) @(negedge clk);

    // Reset during a counting window, then a clean run
    const_val = 16'h0555;
    send_cmd(CMD_MEAS);
    while (!cnt_en) @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst gate");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    base = cap.size();
    send_cmd(CMD_MEAS);
    wait_bytes("after rst", base + int'(FRAME_LEN), 20000, 1'b1);
    check_frame("after rst", base, 8'hA5, 16'h0555, 16'h0555);

    check("start while busy", 32'(viol), 32'd0);
    check("enables exclusive", 32'(onehot_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ro_measure_sequencer.md
# ro_measure_sequencer

Measurement sequencer for the ring-oscillator temperature sensor. It takes a command from the UART receiver and runs both oscillators in turn: the inverter ring first, then the NAND ring. For each oscillator it opens a fixed counting window a set number of times and accumulates the counts, then sends a framed two-result packet through the UART transmitter. It sits between `uart_basic` and the `contador` counter, and replaces the ad-hoc enable/select pins with sequenced control.

## Interface
Parameters:
- `WINDOW_CYCLES`, 10000: length of each counting window, in `clk` cycles.
- `SETTLE_CYCLES`, 16: cycles between enabling an oscillator and opening its first window. Also used as the hold time after each window closes.
- `SAMPLES_LOG2`, 3: log2 of the number of windows averaged per oscillator (8).

Ports:
- `clk`  in  1  system clock; the block uses one clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx_data`  in  8  received command byte.
- `rx_ready`  in  1  one-cycle pulse; `rx_data` is valid in that cycle.
- `count`  in  16  counter value, stable while `cnt_en` is low.
- `tx_busy`  in  1  transmitter busy.
- `en_inv_osc`  out  1  enables the inverter ring.
- `en_nand_osc`  out  1  enables the NAND ring.
- `osc_sel`  out  1  selects the oscillator: 0 = inverter, 1 = NAND.
- `cnt_en`  out  1  counting window gate.
- `cnt_clear`  out  1  one-cycle counter clear.
- `tx_start`  out  1  one-cycle transmit request.
- `tx_data`  out  8  byte to transmit.
- `busy`  out  1  high from leaving IDLE until the last byte has been handed off.

## Operation
- Commands:
  - 0x4D ('M') runs one measurement.
  - 0x43 ('C') runs measurements continuously.
  - 0x53 ('S') stops continuous mode.
  - All other bytes are ignored.
- Command handling in IDLE: 'M' or 'C' starts a run; 'C' also sets the `cont` flag.
- Command handling while busy: 'S' clears `cont` and the current frame completes. 'M' and 'C' are ignored.
- State flow: IDLE → SETTLE → GATE → HOLD → ACCUM → (SETTLE for the next window, or the next oscillator) → SEND → IDLE.
- SETTLE:
  - The selected oscillator's enable is high; `osc_sel` is set.
  - `cnt_clear` pulses in the first SETTLE cycle.
  - SETTLE lasts `SETTLE_CYCLES` cycles.
- GATE: `cnt_en` is high for exactly `WINDOW_CYCLES` cycles.
- HOLD: `cnt_en` is low for `SETTLE_CYCLES` cycles so `count` can settle across domains.
- ACCUM: `count` is added to the accumulator in one cycle. The accumulator is (16+`SAMPLES_LOG2`) bits wide and cannot overflow.
- Saturation: if any sampled `count` equals 0xFFFF, the `sat` flag is set for the frame.
- Switching oscillators: after 2^`SAMPLES_LOG2` windows on the inverter ring, the result is stored as `acc >> SAMPLES_LOG2` (16 bits). The accumulator is cleared, `en_inv_osc` drops and the NAND ring starts in SETTLE.
- Oscillator enables are mutually exclusive. Both are low in IDLE and SEND.
- SEND frame, in order:
  1. Header: 0xA5, or 0xA7 if `sat` is set.
  2. Inverter result, high byte then low byte.
  3. NAND result, high byte then low byte.
- SEND handshake, per byte:
  - `tx_data` is driven and held until the byte is accepted.
  - `tx_start` pulses when `tx_busy` is low.
  - The block waits one cycle, then waits for `tx_busy` low before sending the next byte.
- After the last byte: if `cont` is set, the block goes back to SETTLE on the inverter ring and `busy` stays high. Otherwise it returns to IDLE.

## Timing
- Reset values: all outputs are 0, the state is IDLE, and `cont`, `sat`, the accumulators and the results are cleared.
- Reset takes effect in any state; a partial frame is discarded.
- `rx_ready` pulse accepted in IDLE: `busy` is high on the next cycle.
- Per oscillator: 2^`SAMPLES_LOG2` × (2·`SETTLE_CYCLES` + `WINDOW_CYCLES` + 1) cycles.
- `tx_start` is never asserted while `tx_busy` is high.
- An `rx_ready` pulse in the same cycle as the last byte's handoff is processed in the state the block enters next.

## Configuration
- `RO_SEQ_CHECKSUM_EN` defined: a sixth byte is appended to the frame. It is the XOR of the preceding five bytes.
- Not defined: the frame is 5 bytes and the checksum logic is absent.

## Structure
- Package `ro_seq_pkg` holds:
  - the state enum;
  - the command constants (CMD_MEAS, CMD_CONT, CMD_STOP);
  - the header constants (HDR_OK = 0xA5, HDR_SAT = 0xA7);
  - the frame length.
- Sub-module `ro_frame_tx`:
  - inputs: a byte index and the `tx_busy` handshake;
  - outputs: `tx_data`, `tx_start` and a frame-done pulse;
  - handles byte selection and the checksum.

## Test plan
- Single run, 'M': constant `count` = 0x1234 → frame A5 12 34 12 34 → IDLE with `busy` low.
- Per-sample averaging: `count` sequence 100..107 on the inverter ring → inverter result = 103 (0x0067).
- Saturation: one sample of 0xFFFF → header 0xA7.
- Continuous mode: 'C', then 'S' sent mid-window → that frame completes, then IDLE; no second frame.
- Handshake: `tx_busy` held high for 500 cycles per byte → no `tx_start` while busy; the byte order is intact.
- Reset during GATE: outputs are 0 and the state is IDLE the next cycle. A following 'M' produces a full, correct frame (6 bytes with a correct XOR when `RO_SEQ_CHECKSUM_EN` is defined).
